ahb_lite_master_arb: RTL and testbench
======================================

# ahb_lite_master_arb

Two-master AHB-Lite arbiter that shares the single AHB-Lite slave port of the AHB-to-AXI4 bridge between two AHB-Lite masters, e.g. the debug module and an external DMA. It forwards one address phase at a time with zero added latency when uncontended. It tracks data-phase ownership to route read data and responses, and holds a completed response in a one-entry buffer when the finishing master loses the next arbitration. Masters are single-transfer only: htrans is IDLE/NONSEQ and hburst is SINGLE, as the bridge requires.

## Interface
- DW, default 64: data width.
- AW, default 32: address width.
- PRIO_M0, default 0: 0 selects round-robin; 1 gives M0 fixed priority.

Ports:
- clk  in  1  AHB clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- m0_/m1_ haddr, hsize, htrans, hwrite, hwdata, hmastlock, hprot, hburst  in  AW/3/2/1/DW/1/4/3  master address and data phase.
- m0_/m1_ hrdata  out  DW  read data to the master.
- m0_/m1_ hready  out  1  ready to the master.
- m0_/m1_ hresp  out  1  error response to the master.
- s_haddr, s_hsize, s_htrans, s_hwrite, s_hwdata, s_hmastlock, s_hprot, s_hburst  out  widths as above  to the bridge.
- s_hsel  out  1  to the bridge.
- s_hreadyin  out  1  to the bridge.
- s_hrdata  in  DW  from the bridge.
- s_hreadyout  in  1  from the bridge.
- s_hresp  in  1  from the bridge.

## Operation
- Request: req_i = mi_htrans[1]. Bus-ready: brdy = s_hreadyout. s_hreadyin = brdy. s_hsel = 1.
- Bus FSM:
  - B_IDLE (no data phase).
  - B_DPH (data phase owned by dph_own).
  - B_ERR (first cycle of an error response seen: s_hresp=1, brdy=0).
  - Transitions:
    - On brdy with a winner: go to B_DPH and set dph_own to the winner.
    - On brdy with no winner: go to B_IDLE.
    - From B_DPH, s_hresp & ~brdy: go to B_ERR.
    - From B_ERR on brdy: re-arbitrate as above.
- Winner, evaluated combinationally and used only when brdy=1. Priority order:
  1. lock_vld: only lock_own may win.
  2. hold_vld: the held master.
  3. B_ERR: dph_own, if it is requesting.
  4. Both requesting: ~rr_last, or M0 when PRIO_M0=1.
  5. Otherwise: the single requester.
- Address mux: s_* = winner's signals and s_htrans = NONSEQ. With no winner, s_htrans = IDLE and other s_* are don't-care but driven from M0.
- s_hwdata is mi_hwdata of dph_own.
- rr_last <= winner on each accepted NONSEQ.
- Lock:
  - lock_vld set when an accepted transfer has hmastlock=1.
  - Cleared when the owner's next accepted transfer has hmastlock=0, or on owner IDLE at brdy.
- Master i response:
  - Held (hold_vld & hold_own==i):
    - hready_i = brdy & win_i.
    - hrdata_i = hold_rdata.
    - hresp_i = 0.
  - Data-phase owner:
    - hready_i = brdy & (~req_i | win_i | s_hresp).
    - hresp_i = s_hresp.
    - hrdata_i = s_hrdata.
  - Otherwise:
    - hready_i = ~req_i | (brdy & win_i).
    - hresp_i = 0.
    - hrdata_i = s_hrdata.
- Hold capture: when brdy & ~s_hresp and dph_own requests but loses:
  - hold_vld <= 1, hold_own <= dph_own, hold_rdata <= s_hrdata.
  - That master's hready stays low until it is granted.
- Hold clear: when the held master is granted, hold_vld <= 0.
- Simultaneous clear and capture: capture wins, so the entry is reloaded for the other master.
- Error responses are never held; the owner gets priority in B_ERR instead.

## Timing
- Uncontended: address reaches the slave in the same cycle, with a combinational path mi_htrans → s_htrans and mi_hready. Data-phase responses are combinational pass-through.
- Contended loser: stalled ≥1 cycle, holding its address.
- Held master: receives hrdata on the cycle its next address is accepted, 1+ cycles after the slave completed.
- Reset values:
  - Registers: state=B_IDLE, dph_own=0, rr_last=1 (M0 wins first tie), lock_vld=0, hold_vld=0, hold_rdata=0.
  - Outputs: mi_hready=1, mi_hresp=0, s_htrans=IDLE when no request.
- Reset mid-transfer: all state clears immediately (asynchronous); in-flight responses are dropped.

## Structure
- Shared package ahb_arb_pkg: bus FSM state enum (B_IDLE, B_DPH, B_ERR), HTRANS_IDLE/NONSEQ constants, master-index typedef.
- Sub-module ahb_arb_rr2: 2-requester round-robin/fixed-priority picker with lock and hold override inputs.

## Test plan
- M0 read 0x0000_1000 hsize=2 alone → s_htrans=2 and s_haddr=0x1000 the same cycle; s_hrdata=0xDEADBEEF next cycle → m0_hrdata=0xDEADBEEF, m0_hready=1.
- First cycle after reset, M0 and M1 both NONSEQ → M0 forwarded, m1_hready=0; at next brdy M1 is forwarded; a further tie → M0 (round-robin).
- M0 back-to-back reads with M1 contending → M0's data 0x1234 is captured into the hold and m0_hready=0 while M1 is forwarded. On the next brdy, M0 is granted with m0_hready=1 and m0_hrdata=0x1234.
- Slave error on an M1 write → m1_hresp=1, m1_hready=0, then m1_hresp=1, m1_hready=1; m0_hresp stays 0. A new M1 request in B_ERR beats a waiting M0.
- M1 issues three transfers with hmastlock=1 while M0 requests → M0 stalls until M1's unlocked transfer is accepted, then M0 is forwarded.
- rst asserted during an M0 data phase with the hold valid → m0_hready=1, hresp=0, s_htrans=0 in the same cycle; the next M1 request is forwarded normally.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// Shared types for the two-master AHB-Lite arbiter.
//   bus_state_e : data-phase tracking FSM (B_IDLE, B_DPH, B_ERR)
//   HTRANS_*    : the only transfer types the masters and bridge use
//   mst_idx_t   : master index (0 = M0, 1 = M1)
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_DPH  = 2'd1,
    B_ERR  = 2'd2
  } bus_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef logic mst_idx_t;

endpackage

// File: rtl/ahb_lite_master_arb_if.sv
// AHB-Lite single-transfer port bundle.
//   master modport : drives address/control/write data, receives hrdata/hready/hresp
//   slave  modport : receives address/control/write data, drives hrdata/hready/hresp
// On the bridge side hready carries hreadyout; hsel/hreadyin are only
// meaningful towards the bridge.
interface ahb_lite_master_arb_if #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 32
) ();
  logic [AW-1:0] haddr;
  logic [2:0]    hsize;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [DW-1:0] hwdata;
  logic          hmastlock;
  logic [3:0]    hprot;
  logic [2:0]    hburst;
  logic          hsel;
  logic          hreadyin;
  logic [DW-1:0] hrdata;
  logic          hready;
  logic          hresp;

  modport master (
    output haddr, hsize, htrans, hwrite, hwdata, hmastlock, hprot, hburst,
           hsel, hreadyin,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, hsize, htrans, hwrite, hwdata, hmastlock, hprot, hburst,
           hsel, hreadyin,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_arb_rr2.sv
// Two-requester picker.
//   req      : request per master
//   rr_last  : master granted last (tie-break, round-robin mode)
//   lock_*   : bus locked to lock_own; nobody else may win
//   hold_*   : master whose read data sits in the hold buffer
//   err_*    : second error cycle; owner keeps the bus if requesting
//   win_vld/win_idx : combinational winner
module ahb_arb_rr2
  import ahb_arb_pkg::*;
#(
  parameter bit PRIO_M0 = 1'b0
) (
  input  logic [1:0] req,
  input  mst_idx_t   rr_last,
  input  logic       lock_vld,
  input  mst_idx_t   lock_own,
  input  logic       hold_vld,
  input  mst_idx_t   hold_own,
  input  logic       err_vld,
  input  mst_idx_t   err_own,
  output logic       win_vld,
  output mst_idx_t   win_idx
);

  always_comb begin
    win_vld = 1'b0;
    win_idx = 1'b0;
    if (lock_vld) begin
      win_vld = req[lock_own];
      win_idx = lock_own;
    end else if (hold_vld && req[hold_own]) begin
      win_vld = 1'b1;
      win_idx = hold_own;
    end else if (err_vld && req[err_own]) begin
      win_vld = 1'b1;
      win_idx = err_own;
    end else if (&req) begin
      win_vld = 1'b1;
      win_idx = PRIO_M0 ? 1'b0 : ~rr_last;
    end else if (req[1]) begin
      win_vld = 1'b1;
      win_idx = 1'b1;
    end else if (req[0]) begin
      win_vld = 1'b1;
      win_idx = 1'b0;
    end
  end

endmodule

// File: rtl/ahb_lite_master_arb.sv
// Shares the AHB-to-AXI4 bridge slave port between two single-transfer
// AHB-Lite masters with zero added latency when uncontended.
//   clk, rst : clock, asynchronous active-high reset
//   m0, m1   : upstream master ports (arbiter acts as their slave)
//   s        : downstream bridge port (s.hready is the bridge hreadyout)
module ahb_lite_master_arb
  import ahb_arb_pkg::*;
#(
  parameter int unsigned DW      = 64,
  parameter int unsigned AW      = 32,
  parameter bit          PRIO_M0 = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  ahb_lite_master_arb_if.slave  m0,
  ahb_lite_master_arb_if.slave  m1,
  ahb_lite_master_arb_if.master s
);

  bus_state_e    state_q, state_d;
  mst_idx_t      dph_own_q, dph_own_d, rr_last_q, rr_last_d;
  mst_idx_t      lock_own_q, lock_own_d, hold_own_q, hold_own_d;
  logic          lock_vld_q, lock_vld_d, hold_vld_q, hold_vld_d;
  logic [DW-1:0] hold_rdata_q, hold_rdata_d;

  logic [1:0]    req;
  logic          brdy, win_vld, accept, capture, sel_lock;
  mst_idx_t      win_idx, sel;
  logic [AW-1:0] sel_haddr;
  logic [1:0]    hready, hresp, use_hold;

  assign req    = {m1.htrans[1], m0.htrans[1]};
  assign brdy   = s.hready;
  assign accept = brdy & win_vld;
  assign sel    = win_vld ? win_idx : 1'b0;

  ahb_arb_rr2 #(.PRIO_M0(PRIO_M0)) u_pick (
    .req      (req),
    .rr_last  (rr_last_q),
    .lock_vld (lock_vld_q),
    .lock_own (lock_own_q),
    .hold_vld (hold_vld_q),
    .hold_own (hold_own_q),
    .err_vld  (state_q == B_ERR),
    .err_own  (dph_own_q),
    .win_vld  (win_vld),
    .win_idx  (win_idx)
  );

  // Address phase: winner's controls, M0's when nobody wins.
  assign sel_haddr   = sel ? m1.haddr : m0.haddr;
  assign sel_lock    = sel ? m1.hmastlock : m0.hmastlock;
  assign s.haddr     = sel_haddr;
  assign s.hmastlock = sel_lock;
  assign s.hsize     = sel ? m1.hsize  : m0.hsize;
  assign s.hwrite    = sel ? m1.hwrite : m0.hwrite;
  assign s.hprot     = sel ? m1.hprot  : m0.hprot;
  assign s.hburst    = sel ? m1.hburst : m0.hburst;
  assign s.htrans    = win_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign s.hwdata    = dph_own_q ? m1.hwdata : m0.hwdata;
  assign s.hsel      = 1'b1;
  assign s.hreadyin  = brdy;

  // Owner's data completes cleanly but it loses the next address slot:
  // park the read data until it is granted.
  assign capture = brdy & ~s.hresp & (state_q == B_DPH) & req[dph_own_q]
                 & ~(win_vld & (win_idx == dph_own_q));

  always_comb begin
    state_d      = state_q;
    dph_own_d    = dph_own_q;
    rr_last_d    = rr_last_q;
    lock_vld_d   = lock_vld_q;
    lock_own_d   = lock_own_q;
    hold_vld_d   = hold_vld_q;
    hold_own_d   = hold_own_q;
    hold_rdata_d = hold_rdata_q;

    if (brdy) begin
      state_d = win_vld ? B_DPH : B_IDLE;
      if (win_vld) dph_own_d = win_idx;
    end else if (state_q == B_DPH && s.hresp) begin
      state_d = B_ERR;
    end

    if (accept) begin
      rr_last_d = win_idx;
      if (sel_lock) begin
        lock_vld_d = 1'b1;
        lock_own_d = win_idx;
      end else begin
        lock_vld_d = 1'b0;
      end
    end else if (brdy && lock_vld_q && !req[lock_own_q]) begin
      lock_vld_d = 1'b0;
    end

    if (hold_vld_q && accept && (win_idx == hold_own_q)) hold_vld_d = 1'b0;
    // A capture in the same cycle reloads the entry for the other master.
    if (capture) begin
      hold_vld_d   = 1'b1;
      hold_own_d   = dph_own_q;
      hold_rdata_d = s.hrdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= B_IDLE;
      dph_own_q    <= 1'b0;
      rr_last_q    <= 1'b1;
      lock_vld_q   <= 1'b0;
      lock_own_q   <= 1'b0;
      hold_vld_q   <= 1'b0;
      hold_own_q   <= 1'b0;
      hold_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      dph_own_q    <= dph_own_d;
      rr_last_q    <= rr_last_d;
      lock_vld_q   <= lock_vld_d;
      lock_own_q   <= lock_own_d;
      hold_vld_q   <= hold_vld_d;
      hold_own_q   <= hold_own_d;
      hold_rdata_q <= hold_rdata_d;
    end
  end

  always_comb begin
    hready   = '0;
    hresp    = '0;
    use_hold = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (hold_vld_q && hold_own_q == mst_idx_t'(i)) begin
        hready[i]   = brdy & win_vld & (win_idx == mst_idx_t'(i));
        use_hold[i] = 1'b1;
      end else if (state_q != B_IDLE && dph_own_q == mst_idx_t'(i)) begin
        hready[i] = brdy & (~req[i] | (win_vld & (win_idx == mst_idx_t'(i))) | s.hresp);
        hresp[i]  = s.hresp;
      end else begin
        hready[i] = ~req[i] | (brdy & win_vld & (win_idx == mst_idx_t'(i)));
      end
    end
  end

  assign m0.hready = hready[0];
  assign m1.hready = hready[1];
  assign m0.hresp  = hresp[0];
  assign m1.hresp  = hresp[1];
  assign m0.hrdata = use_hold[0] ? hold_rdata_q : s.hrdata;
  assign m1.hrdata = use_hold[1] ? hold_rdata_q : s.hrdata;

endmodule

// File: tb/tb_ahb_lite_master_arb.sv
// Bench for ahb_lite_master_arb: directed scenarios followed by random
// reads checked end-to-end against a transaction-level model.
module tb_ahb_lite_master_arb;
  import ahb_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  ahb_lite_master_arb_if #(.DW(64), .AW(32)) m0_if ();
  ahb_lite_master_arb_if #(.DW(64), .AW(32)) m1_if ();
  ahb_lite_master_arb_if #(.DW(64), .AW(32)) s_if ();

  ahb_lite_master_arb #(.DW(64), .AW(32), .PRIO_M0(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int unsigned i, input logic [1:0] tr, input logic [31:0] a,
                     input logic w, input logic lk, input logic [63:0] wd);
    if (i == 0) begin
      m0_if.htrans = tr; m0_if.haddr = a; m0_if.hwrite = w;
      m0_if.hmastlock = lk; m0_if.hwdata = wd;
    end else begin
      m1_if.htrans = tr; m1_if.haddr = a; m1_if.hwrite = w;
      m1_if.hmastlock = lk; m1_if.hwdata = wd;
    end
  endtask

  task automatic slv(input logic rdy, input logic rsp, input logic [63:0] rd);
    s_if.hready = rdy; s_if.hresp = rsp; s_if.hrdata = rd;
  endtask

  function automatic logic [63:0] rdata_of(input logic [31:0] a);
    return {~a, a} ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  // random-phase model state
  logic [31:0] ra   [2];
  logic        rr   [2];
  logic        dp   [2];
  logic [31:0] da   [2];
  int unsigned wt   [2];
  int unsigned done [2];
  logic        h    [2];
  logic [63:0] rd   [2];
  logic        spend, sbrdy, sacc;
  logic [31:0] saddr, sa;

  initial begin
    m0_if.hsize = 3'd2; m0_if.hprot = 4'h3; m0_if.hburst = 3'd0;
    m0_if.hsel = 1'b1;  m0_if.hreadyin = 1'b1;
    m1_if.hsize = 3'd2; m1_if.hprot = 4'h3; m1_if.hburst = 3'd0;
    m1_if.hsel = 1'b1;  m1_if.hreadyin = 1'b1;
    drv(0, HTRANS_IDLE, 0, 0, 0, 0);
    drv(1, HTRANS_IDLE, 0, 0, 0, 0);
    slv(1'b1, 1'b0, 64'h0);

    // reset state
    #2;
    chk("rst_m0_hready", m0_if.hready, 1);
    chk("rst_m1_hready", m1_if.hready, 1);
    chk("rst_m0_hresp", m0_if.hresp, 0);
    chk("rst_s_htrans", s_if.htrans, HTRANS_IDLE);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();

    // tie after reset -> M0, then M1, then tie -> M0 with M1 held
    drv(0, HTRANS_NONSEQ, 32'h100, 0, 0, 0);
    drv(1, HTRANS_NONSEQ, 32'h200, 0, 0, 0);
    #1;
    chk("tie1_haddr", s_if.haddr, 32'h100);
    chk("tie1_m0_hready", m0_if.hready, 1);
    chk("tie1_m1_hready", m1_if.hready, 0);
    tick();
    drv(0, HTRANS_IDLE, 0, 0, 0, 0);
    slv(1'b1, 1'b0, 64'hAAAA);
    #1;
    chk("tie2_haddr", s_if.haddr, 32'h200);
    chk("tie2_m1_hready", m1_if.hready, 1);
    chk("tie2_m0_hrdata", m0_if.hrdata, 64'hAAAA);
    tick();
    drv(0, HTRANS_NONSEQ, 32'h300, 0, 0, 0);
    drv(1, HTRANS_NONSEQ, 32'h400, 0, 0, 0);
    slv(1'b1, 1'b0, 64'hBBBB);
    #1;
    chk("tie3_haddr", s_if.haddr, 32'h300);
    chk("tie3_m1_hready", m1_if.hready, 0);
    tick();
    drv(0, HTRANS_IDLE, 0, 0, 0, 0);
    slv(1'b1, 1'b0, 64'hCCCC);
    #1;
    chk("hold1_haddr", s_if.haddr, 32'h400);
    chk("hold1_m1_hready", m1_if.hready, 1);
    chk("hold1_m1_hrdata", m1_if.hrdata, 64'hBBBB);
    chk("hold1_m0_hrdata", m0_if.hrdata, 64'hCCCC);
    tick();
    drv(1, HTRANS_IDLE, 0, 0, 0, 0);
    slv(1'b1, 1'b0, 64'hDDDD);
    #1;
    chk("hold1_m1_next", m1_if.hrdata, 64'hDDDD);
    tick();

    // uncontended M0 read
    drv(0, HTRANS_NONSEQ, 32'h0000_1000, 0, 0, 0);
    #1;
    chk("solo_htrans", s_if.htrans, HTRANS_NONSEQ);
    chk("solo_haddr", s_if.haddr, 32'h1000);
    chk("solo_hsize", s_if.hsize, 3'd2);
    tick();
    drv(0, HTRANS_IDLE, 0, 0, 0, 0);
    slv(1'b1, 1'b0, 64'hDEADBEEF);
    #1;
    chk("solo_hrdata", m0_if.hrdata, 64'hDEADBEEF);
    chk("solo_hready", m0_if.hready, 1);
    tick();

    // M0 back-to-back with M1 contending -> M0 data held
    drv(0, HTRANS_NONSEQ, 32'h2000, 0, 0, 0);
    tick();
    drv(0, HTRANS_NONSEQ, 32'h2008, 0, 0, 0);
    drv(1, HTRANS_NONSEQ, 32'h3000, 0, 0, 0);
    slv(1'b1, 1'b0, 64'h1234);
    #1;
    chk("hold2_haddr", s_if.haddr, 32'h3000);
    chk("hold2_m0_hready", m0_if.hready, 0);
    tick();
    drv(1, HTRANS_IDLE, 0, 0, 0, 0);
    slv(1'b1, 1'b0, 64'h5555);
    #1;
    chk("hold2_grant_haddr", s_if.haddr, 32'h2008);
    chk("hold2_m0_hready", m0_if.hready, 1);
    chk("hold2_m0_hrdata", m0_if.hrdata, 64'h1234);
    chk("hold2_m1_hrdata", m1_if.hrdata, 64'h5555);
    tick();
    drv(0, HTRANS_IDLE, 0, 0, 0, 0);
    slv(1'b1, 1'b0, 64'h6666);
    #1;
    chk("hold2_m0_last", m0_if.hrdata, 64'h6666);
    tick();

    // error on M1 write; M1 re-request in B_ERR beats waiting M0
    drv(1, HTRANS_NONSEQ, 32'h4000, 1, 0, 0);
    tick();
    drv(1, HTRANS_NONSEQ, 32'h4008, 1, 0, 64'hF1);
    drv(0, HTRANS_NONSEQ, 32'h5000, 0, 0, 0);
    slv(1'b0, 1'b1, 64'h0);
    #1;
    chk("err1_hwdata", s_if.hwdata, 64'hF1);
    chk("err1_m1_hresp", m1_if.hresp, 1);
    chk("err1_m1_hready", m1_if.hready, 0);
    chk("err1_m0_hresp", m0_if.hresp, 0);
    tick();
    slv(1'b1, 1'b1, 64'h0);
    #1;
    chk("err2_m1_hresp", m1_if.hresp, 1);
    chk("err2_m1_hready", m1_if.hready, 1);
    chk("err2_haddr", s_if.haddr, 32'h4008);
    chk("err2_m0_hready", m0_if.hready, 0);
    chk("err2_m0_hresp", m0_if.hresp, 0);
    tick();
    drv(1, HTRANS_IDLE, 0, 0, 0, 64'hF2);
    slv(1'b1, 1'b0, 64'h77);
    #1;
    chk("err3_haddr", s_if.haddr, 32'h5000);
    chk("err3_hwdata", s_if.hwdata, 64'hF2);
    chk("err3_m1_hresp", m1_if.hresp, 0);
    tick();
    drv(0, HTRANS_IDLE, 0, 0, 0, 0);
    tick();

    // locked sequence from M1
    drv(1, HTRANS_NONSEQ, 32'h6000, 0, 1, 0);
    tick();
    drv(1, HTRANS_NONSEQ, 32'h6008, 0, 1, 0);
    drv(0, HTRANS_NONSEQ, 32'h7000, 0, 0, 0);
    #1;
    chk("lock2_haddr", s_if.haddr, 32'h6008);
    chk("lock2_m0_hready", m0_if.hready, 0);
    tick();
    drv(1, HTRANS_NONSEQ, 32'h6010, 0, 1, 0);
    #1;
    chk("lock3_haddr", s_if.haddr, 32'h6010);
    tick();
    drv(1, HTRANS_NONSEQ, 32'h6018, 0, 0, 0);
    #1;
    chk("lock4_haddr", s_if.haddr, 32'h6018);
    chk("lock4_hmastlock", s_if.hmastlock, 0);
    chk("lock4_m0_hready", m0_if.hready, 0);
    tick();
    drv(1, HTRANS_IDLE, 0, 0, 0, 0);
    #1;
    chk("lock5_haddr", s_if.haddr, 32'h7000);
    chk("lock5_m0_hready", m0_if.hready, 1);
    tick();
    drv(0, HTRANS_IDLE, 0, 0, 0, 0);
    tick();

    // reset with M0 data held
    drv(0, HTRANS_NONSEQ, 32'h8000, 0, 0, 0);
    tick();
    drv(0, HTRANS_NONSEQ, 32'h8008, 0, 0, 0);
    drv(1, HTRANS_NONSEQ, 32'h9000, 0, 0, 0);
    slv(1'b1, 1'b0, 64'h88);
    tick();
    drv(0, HTRANS_IDLE, 0, 0, 0, 0);
    drv(1, HTRANS_IDLE, 0, 0, 0, 0);
    slv(1'b0, 1'b0, 64'h0);
    #1;
    chk("prerst_m0_hready", m0_if.hready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_m0_hready", m0_if.hready, 1);
    chk("midrst_m0_hresp", m0_if.hresp, 0);
    chk("midrst_s_htrans", s_if.htrans, HTRANS_IDLE);
    @(negedge clk);
    rst = 1'b0;
    slv(1'b1, 1'b0, 64'h0);
    tick();
    drv(1, HTRANS_NONSEQ, 32'hA000, 0, 0, 0);
    #1;
    chk("postrst_haddr", s_if.haddr, 32'hA000);
    chk("postrst_m1_hready", m1_if.hready, 1);
    tick();
    drv(1, HTRANS_IDLE, 0, 0, 0, 0);
    tick();

    // random reads: every accepted address reaches the bridge exactly once
    // and every master sees the data belonging to its own address
    for (int i = 0; i < 2; i++) begin
      ra[i] = 0; rr[i] = 0; dp[i] = 0; da[i] = 0; wt[i] = 0; done[i] = 0;
    end
    spend = 1'b0; saddr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      h[0] = m0_if.hready; h[1] = m1_if.hready;
      rd[0] = m0_if.hrdata; rd[1] = m1_if.hrdata;
      sbrdy = s_if.hready;
      sacc  = sbrdy & (s_if.htrans == HTRANS_NONSEQ);
      sa    = s_if.haddr;
      for (int i = 0; i < 2; i++) begin
        if (h[i] && dp[i]) chk(i == 0 ? "rnd_m0_rdata" : "rnd_m1_rdata", rd[i], rdata_of(da[i]));
        if (h[i] && rr[i]) chk(i == 0 ? "rnd_m0_addr" : "rnd_m1_addr", sa, ra[i]);
        wt[i] = (rr[i] && !h[i]) ? wt[i] + 1 : 0;
        chk("rnd_wait_bound", (wt[i] <= 40), 1);
      end
      chk("rnd_accept_count", 64'(int'(h[0] & rr[0]) + int'(h[1] & rr[1])), 64'(sacc));
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (h[i]) begin
          if (dp[i]) done[i]++;
          dp[i] = rr[i];
          if (rr[i]) da[i] = ra[i];
        end
        if (!rr[i] || h[i]) begin
          rr[i] = ($urandom_range(0, 9) < 7);
          ra[i] = $urandom & 32'hFFFF_FFF8;
        end
        drv(i, rr[i] ? HTRANS_NONSEQ : HTRANS_IDLE, ra[i], 0, 0, 0);
      end
      if (sbrdy) begin
        spend = sacc;
        if (sacc) saddr = sa;
      end
      s_if.hready = spend ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_if.hrdata = (spend && s_if.hready) ? rdata_of(saddr) : {$urandom, $urandom};
    end
    chk("rnd_m0_progress", (done[0] > 100), 1);
    chk("rnd_m1_progress", (done[1] > 100), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
